// File: rtl/proc_bus_pkg.sv
// Shared types and constants for the accumulator operand-bus arbiter.
package proc_bus_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Arbitration result handed from the picker to the sequencer.
  typedef struct packed {
    logic       any;
    logic [1:0] idx;
  } pick_t;

  // Successor of a requester index in round-robin order (C wraps to A).
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == SEL_C) ? SEL_A : i + 2'd1;
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [2:0] onehot3(input logic [1:0] i);
    logic [2:0] v;
    v = 3'b000;
    unique case (i)
      SEL_B:   v = 3'b010;
      SEL_C:   v = 3'b100;
      default: v = 3'b001;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_3r_if.sv
// Requester/bus bundle for the 3-input operand bus arbiter.
interface bus_arbiter_3r_if #(
  parameter int DW = 4
);
  logic [2:0]    req;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [DW-1:0] c_data;
  logic [2:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] bus_data;
  logic          bus_valid;
  logic          busy;

  // Requester side: drives requests and data, observes grant and bus.
  modport master (
    output req, a_data, b_data, c_data,
    input  gnt, sel, bus_data, bus_valid, busy
  );

  // Arbiter side.
  modport slave (
    input  req, a_data, b_data, c_data,
    output gnt, sel, bus_data, bus_valid, busy
  );
endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick3
  import proc_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] p0, p1, p2;

  // Rotate the priority order to start at ptr, then take the first hit.
  always_comb begin
    p0 = SEL_A;
    p1 = SEL_B;
    p2 = SEL_C;
    unique case (ptr)
      SEL_B: begin p0 = SEL_B; p1 = SEL_C; p2 = SEL_A; end
      SEL_C: begin p0 = SEL_C; p1 = SEL_A; p2 = SEL_B; end
      default: ;
    endcase
    any = |req;
    if (req[p0])      win = p0;
    else if (req[p1]) win = p1;
    else if (req[p2]) win = p2;
    else              win = p0;
  end

endmodule

// File: rtl/bus_arbiter_3r.sv
// Round-robin arbiter/sequencer for the shared 3-input operand bus.
// Grants one requester at a time, registers the selected data onto the bus,
// and caps each tenure at MAX_BURST beats.
module bus_arbiter_3r
  import proc_bus_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arbiter_3r_if.slave  bus
);

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  state_t        state;
  logic [1:0]    ptr;
  logic [3:0]    cnt;
  logic [2:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] bus_data;
  logic          bus_valid;
  logic          busy;

  logic [DW-1:0] mux_data;
  logic [3:0]    cnt_inc;
  logic          beat;
  logic          last_beat;
  logic          rel;
  logic [1:0]    pick_ptr;
  pick_t         pick;

  // 3-to-1 operand mux driven by the registered select.
  always_comb begin
    unique case (sel)
      SEL_B:   mux_data = bus.b_data;
      SEL_C:   mux_data = bus.c_data;
      default: mux_data = bus.a_data;
    endcase
  end

  // Beat/release decode for the current owner (owner index is sel).
  always_comb begin
    cnt_inc   = cnt + 4'd1;
    beat      = (state == OWN) && (|(gnt & bus.req));
    last_beat = beat && (cnt_inc == BURST);
    rel       = (state == OWN) && (!beat || last_beat);
    // In IDLE arbitrate from the stored pointer; on release arbitrate from
    // the owner's successor, i.e. the pointer value being written this cycle.
    // A dropped owner is already masked because its req bit is low; a capped
    // owner stays eligible so a sole requester is simply re-granted.
    pick_ptr  = (state == OWN) ? next_idx(sel) : ptr;
  end

  rr_pick3 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .win (pick.idx),
    .any (pick.any)
  );

  // Sequencer: state, pointer, beat counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SEL_A;
      cnt       <= 4'd0;
      gnt       <= 3'b000;
      sel       <= SEL_A;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          gnt <= 3'b000;
          if (pick.any) begin
            state <= OWN;
            busy  <= 1'b1;
            gnt   <= onehot3(pick.idx);
            sel   <= pick.idx;
            cnt   <= 4'd0;
          end
        end
        OWN: begin
          if (beat) begin
            bus_data  <= mux_data;
            bus_valid <= 1'b1;
            cnt       <= cnt_inc;
          end
          if (rel) begin
            ptr <= next_idx(sel);
            if (pick.any) begin
              gnt <= onehot3(pick.idx);
              sel <= pick.idx;
              cnt <= 4'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              gnt   <= 3'b000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.bus_data  = bus_data;
  assign bus.bus_valid = bus_valid;
  assign bus.busy      = busy;

endmodule

// File: doc/bus_arbiter_3r.md
# bus_arbiter_3r

Round-robin arbiter and sequencer for the shared 4-bit, 3-input operand bus in the accumulator datapath. Grants one of three requesters at a time and drives the 2-bit select of the bus's 3-to-1 mux. Registers the selected data onto the bus with a valid strobe. Caps each tenure at a configurable burst length so no requester can starve the others.

## Interface
- `DW`, 4, data width of each requester input and of the bus.
- `MAX_BURST`, 4, maximum beats per grant tenure; legal range is 1 to 15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  request per requester; bit 0 = A, bit 1 = B, bit 2 = C.
- `a_data`  in  DW  requester A data.
- `b_data`  in  DW  requester B data.
- `c_data`  in  DW  requester C data.
- `gnt`  out  3  one-hot grant, registered.
- `sel`  out  2  mux select, registered; 0 = A, 1 = B, 2 = C; never 3.
- `bus_data`  out  DW  registered bus data.
- `bus_valid`  out  1  `bus_data` holds a beat this cycle.
- `busy`  out  1  state is OWN.

## Operation
- **States:** IDLE and OWN. Reset values:
  - state = IDLE, `gnt` = 0, `sel` = 0, `bus_data` = 0, `bus_valid` = 0, `busy` = 0.
  - Priority pointer `ptr` = 0; beat counter `cnt` = 0.
- **Priority order:** `ptr`, then `ptr`+1, then `ptr`+2 (mod 3). The first requester in that order with `req` high wins.
- **IDLE:**
  - If `req` is nonzero, load `gnt`/`sel` with the winner, clear `cnt`, and go to OWN.
  - Otherwise stay in IDLE with `gnt` = 0 and `sel` held.
- **OWN, owner i, beat accepted:** a beat is accepted in a cycle where `gnt[i]` and `req[i]` are both high.
  - `bus_data` <= mux output selected by `sel`; `bus_valid` <= 1; `cnt` <= `cnt`+1.
- **OWN, release:** release occurs when either:
  - `req[i]` is low (no beat that cycle, `bus_valid` <= 0), or
  - the accepted beat makes `cnt` equal `MAX_BURST`.
- **On release:**
  - `ptr` <= (i+1) mod 3.
  - Re-arbitrate in the same cycle using the updated pointer, with `req[i]` masked when it was low.
  - If there is a winner: load `gnt`/`sel`, clear `cnt`, stay in OWN (back-to-back handoff, no idle cycle). Otherwise go to IDLE and set `gnt` <= 0.
- **Non-beat cycles:** `bus_valid` <= 0 and `bus_data` holds its value.
- **Width rule:** `cnt` is 4 bits and is compared with `==` against `MAX_BURST`; it never wraps.
- **Grant invariants:** `gnt` is one-hot or zero, and `sel` always equals the index of the set `gnt` bit whenever `gnt` is nonzero.

## Timing
- **Grant latency:** `req` rises at edge t in IDLE, so `gnt`/`sel` are valid after edge t+1. The first `bus_valid` follows edge t+2.
- **Data latency:** one cycle from beat acceptance to `bus_valid`.
- **Steady state:** a requester holding `req` in OWN gets 1 beat per cycle, `MAX_BURST` beats in total.
- **Handoff:** the new owner's `gnt` is asserted in the cycle immediately after the old owner's last beat.
- **Sole requester at cap:** if the capped owner is the only requester, it is re-granted with `cnt` cleared. `gnt` stays high continuously.
- **Req drop during OWN:** `bus_valid` is 0 in the drop cycle and the following cycle carries the new grant or IDLE.
- **Reset mid-operation:** asserting `rst_n` low immediately forces all outputs and state to their reset values, without waiting for a clock edge. The first grant after release of reset favours A.

## Structure
- **Shared package `proc_bus_pkg`:**
  - state enum (IDLE, OWN);
  - select constants SEL_A = 0, SEL_B = 1, SEL_C = 2;
  - NUM_REQ = 3.
- **Sub-module `rr_pick3`:** combinational. Inputs are `req[2:0]` and `ptr[1:0]`; outputs are winner index[1:0] and `any`. It is used for both the IDLE and the release arbitration.
- **Datapath:** the 3-to-1 data mux stays in the datapath and is driven by `sel`. This block registers the mux output.

## Test plan
- Reset, then `req`=001 with `a_data`=5 held → `gnt`=001 and `sel`=0 after 1 edge. `bus_valid`=1 with `bus_data`=5 after 2 edges, for 4 beats. A is then re-granted, with `cnt` restarting.
- `req`=111 held, data A=1, B=2, C=3 → bus sequence 1,1,1,1,2,2,2,2,3,3,3,3,1… with no idle cycle between tenures.
- B owns and drops `req[1]` after 2 beats while `req[2]` is high → `bus_valid` is 0 for one cycle, then `gnt`=100 and `sel`=2 next cycle.
- `req`=101 from reset → A wins first. After release, C wins even though A is re-requesting.
- `rst_n` pulsed low mid-burst → `gnt`, `bus_valid`, and `busy` all go to 0 immediately, without waiting for an edge. After release, `req`=110 grants B.
- Continuous random `req` for 10k cycles → `gnt` is always one-hot or zero and `sel` matches `gnt`. No tenure exceeds `MAX_BURST` beats, and no active requester waits longer than 2·`MAX_BURST`+2 cycles.
